// File: rtl/beam_align_pkg.sv
// Shared constants, sample/word types and packing helpers for the beam alignment path.
// Also used by the beamform trigger top.
package beam_align_pkg;

  localparam int NCHAN_DEF   = 8;
  localparam int NSAMP_DEF   = 8;
  localparam int NBITS_DEF   = 5;
  localparam int DEPTH_DEF   = 10;
  localparam int DLYBITS_DEF = 7;

  typedef logic [NBITS_DEF-1:0]   sample_t;
  typedef sample_t [NSAMP_DEF-1:0] word_t;

  // Largest delay the history can serve: everything except the word being sampled now.
  function automatic int max_dly(input int depth, input int nsamp);
    return (depth - 1) * nsamp;
  endfunction

  // Word whose samples continue a stream index ramp: sample s holds (n0 + s) mod 2**NBITS.
  function automatic word_t ramp_word(input int unsigned n0);
    word_t w;
    for (int s = 0; s < NSAMP_DEF; s++) w[s] = sample_t'(n0 + s);
    return w;
  endfunction

endpackage

// File: rtl/chan_delay_line.sv
// One channel's sample history plus a registered window picked at a variable sample offset.
// The window is a single indexed part-select over {current word, stored history}.
module chan_delay_line #(
  parameter int NSAMP   = 8,
  parameter int NBITS   = 5,
  parameter int DEPTH   = 10,
  parameter int DLYBITS = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NSAMP*NBITS-1:0] word_i,
  input  logic [DLYBITS-1:0]     dly_i,
  output logic [NSAMP*NBITS-1:0] word_o
);

  localparam int W      = NSAMP * NBITS;
  localparam int MAXDLY = (DEPTH - 1) * NSAMP;
  localparam int IW     = $clog2(DEPTH * W);

  // The word on word_i is the newest history entry, so only DEPTH-1 words are stored.
  // Earliest sample sits at bit 0 of the window.
  logic [(DEPTH-1)*W-1:0] hist_q;
  logic [DEPTH*W-1:0]     win;
  logic [IW-1:0]          base;

  assign win  = {word_i, hist_q};
  // dly_i is clamped upstream to MAXDLY, so base never underflows.
  assign base = IW'((MAXDLY - int'(dly_i)) * NBITS);

  // NOTE: the history is reset, not left as uninitialised memory, because its contents
  // reach data_o directly while the fill counter is still running.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      word_o <= '0;
    end else begin
      hist_q <= win[DEPTH*W-1:W];
      word_o <= win[base +: W];
    end
  end

endmodule

// File: rtl/beam_delay_aligner.sv
// Per-channel sample aligner: shadow/active delay registers with atomic commit, sticky
// range error, fill counter gating valid_o, and NCHAN channel delay lines.
module beam_delay_aligner
  import beam_align_pkg::*;
#(
  parameter int NCHAN   = NCHAN_DEF,
  parameter int NSAMP   = NSAMP_DEF,
  parameter int NBITS   = NBITS_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DLYBITS = DLYBITS_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCHAN*NSAMP*NBITS-1:0] data_i,
  input  logic                         dly_wr_i,
  input  logic [$clog2(NCHAN)-1:0]     dly_addr_i,
  input  logic [DLYBITS-1:0]           dly_data_i,
  input  logic                         update_i,
  output logic [NCHAN*NSAMP*NBITS-1:0] data_o,
  output logic                         valid_o,
  output logic                         dly_err_o
);

  localparam int W      = NSAMP * NBITS;
  localparam int MAXDLY = max_dly(DEPTH, NSAMP);
  localparam int AW     = $clog2(NCHAN);
  localparam int CW     = $clog2(DEPTH + 1);

  logic [NCHAN-1:0][DLYBITS-1:0] shadow_q, shadow_d, active_q;
  logic [DLYBITS-1:0]            wr_val;
  logic                          addr_ok, over;
  logic [CW-1:0]                 fill_q, fill_d;

  // With a power-of-two channel count every address is legal.
  if (NCHAN == (1 << AW)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (dly_addr_i < AW'(NCHAN));
  end

  assign over   = dly_data_i > DLYBITS'(MAXDLY);
  assign wr_val = over ? DLYBITS'(MAXDLY) : dly_data_i;

  // NOTE: shadow_d takes its default before the conditional write, so no latch is inferred.
  // It is also what the commit copies, which makes a same-cycle write part of the commit.
  always_comb begin
    shadow_d = shadow_q;
    if (dly_wr_i && addr_ok) shadow_d[dly_addr_i] = wr_val;
  end

  assign fill_d = update_i               ? '0     :
                  (fill_q == CW'(DEPTH)) ? fill_q : fill_q + CW'(1);

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q  <= '0;
      active_q  <= '0;
      fill_q    <= '0;
      valid_o   <= 1'b0;
      dly_err_o <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (update_i) active_q <= shadow_d;
      fill_q  <= fill_d;
      valid_o <= (fill_d == CW'(DEPTH));
      if (dly_wr_i && (!addr_ok || over)) dly_err_o <= 1'b1;
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    chan_delay_line #(
      .NSAMP  (NSAMP),
      .NBITS  (NBITS),
      .DEPTH  (DEPTH),
      .DLYBITS(DLYBITS)
    ) u_chan (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .word_i(data_i[c*W +: W]),
      .dly_i (active_q[c]),
      .word_o(data_o[c*W +: W])
    );
  end

endmodule

// File: tb/tb_beam_delay_aligner.sv
// Scoreboard bench: a stream-index reference model queues the expected outputs for every
// clock, and an independent monitor compares them against the DUT one step after each edge.
module tb_beam_delay_aligner;
  import beam_align_pkg::*;

  localparam int NCHAN   = 8;
  localparam int NSAMP   = 8;
  localparam int NBITS   = 5;
  localparam int DEPTH   = 10;
  localparam int DLYBITS = 7;
  localparam int W       = NSAMP * NBITS;
  localparam int DW      = NCHAN * W;
  localparam int MAXDLY  = (DEPTH - 1) * NSAMP;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [DW-1:0]            data_i = '0;
  logic                     dly_wr_i = 1'b0;
  logic [$clog2(NCHAN)-1:0] dly_addr_i = '0;
  logic [DLYBITS-1:0]       dly_data_i = '0;
  logic                     update_i = 1'b0;
  logic [DW-1:0]            data_o;
  logic                     valid_o;
  logic                     dly_err_o;

  beam_delay_aligner #(
    .NCHAN(NCHAN), .NSAMP(NSAMP), .NBITS(NBITS), .DEPTH(DEPTH), .DLYBITS(DLYBITS)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .data_i    (data_i),
    .dly_wr_i  (dly_wr_i),
    .dly_addr_i(dly_addr_i),
    .dly_data_i(dly_data_i),
    .update_i  (update_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .dly_err_o (dly_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    logic          valid;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   t = 0;

  // Reference model: every sample since reset, prefixed by MAXDLY zeros of reset history.
  int unsigned mq[NCHAN][$];
  int          m_shadow[NCHAN];
  int          m_active[NCHAN];
  bit          m_err;
  int          since;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCHAN; c++) begin
      mq[c].delete();
      repeat (MAXDLY) mq[c].push_back(0);
      m_shadow[c] = 0;
      m_active[c] = 0;
    end
    m_err = 1'b0;
    since = 0;
    exp_q.delete();
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp(input int tt);
    logic [DW-1:0] r;
    for (int c = 0; c < NCHAN; c++) r[c*W +: W] = ramp_word(tt * NSAMP);
    return r;
  endfunction

  // Drive one clock of stimulus (entered at a negedge), queue what the next edge must produce.
  task automatic step(input logic [DW-1:0] din, input bit wr = 0, input int addr = 0,
                      input int dv = 0, input bit upd = 0);
    exp_t e;
    data_i     = din;
    dly_wr_i   = wr;
    dly_addr_i = 3'(addr);
    dly_data_i = DLYBITS'(dv);
    update_i   = upd;
    e.data = '0;
    for (int c = 0; c < NCHAN; c++)
      for (int s = 0; s < NSAMP; s++)
        mq[c].push_back(int'(din[(c*NSAMP+s)*NBITS +: NBITS]));
    for (int c = 0; c < NCHAN; c++)
      for (int s = 0; s < NSAMP; s++)
        e.data[(c*NSAMP+s)*NBITS +: NBITS] =
          NBITS'(mq[c][mq[c].size() - NSAMP + s - m_active[c]]);
    if (wr) begin
      if (addr >= NCHAN) m_err = 1'b1;
      else if (dv > MAXDLY) begin
        m_shadow[addr] = MAXDLY;
        m_err = 1'b1;
      end else m_shadow[addr] = dv;
    end
    if (upd) begin
      m_active = m_shadow;
      since = 0;
    end else since++;
    e.valid = (since >= DEPTH);
    e.err   = m_err;
    exp_q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic rstep(input bit wr = 0, input int addr = 0, input int dv = 0, input bit upd = 0);
    step(ramp(t), wr, addr, dv, upd);
    t++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_ni && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_o", data_o, e.data);
        check("valid_o", valid_o, e.valid);
        check("dly_err_o", dly_err_o, e.err);
      end
    end
  end

  initial begin : stimulus
    model_reset();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // Random traffic with an over-range write and a commit, then reset mid-cycle.
    for (int i = 0; i < 14; i++) step(rand_data(), i == 2, 1, 100, i == 3);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    check("reset data_o", data_o, '0);
    check("reset valid_o", valid_o, 1'b0);
    check("reset dly_err_o", dly_err_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();

    // Zero delay everywhere: output is the input one clock later; valid after DEPTH clocks.
    rstep(0, 0, 0, 1);
    repeat (2 * DEPTH) rstep();

    // Sub-word delay on channel 3, written through on the commit cycle.
    rstep(1, 3, 3, 1);
    repeat (2 * DEPTH) rstep();

    // Maximum delay and an over-range write clamped to it.
    rstep(1, 2, MAXDLY, 0);
    rstep(1, 5, 100, 1);
    repeat (DEPTH + 4) step(rand_data());

    // Shadow writes alone must not disturb data_o; then commit with a same-cycle ch0 write.
    for (int c = 0; c < NCHAN; c++) rstep(1, c, $urandom_range(0, MAXDLY), 0);
    repeat (3) rstep();
    rstep(1, 0, $urandom_range(0, MAXDLY), 1);
    repeat (DEPTH + 2) rstep();

    // update_i held for five clocks.
    repeat (5) step(rand_data(), 0, 0, 0, 1);
    repeat (DEPTH + 3) step(rand_data());

    // Random mix of writes, commits and data.
    repeat (300) begin
      int dv;
      dv = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXDLY + 1, 127) : $urandom_range(0, MAXDLY);
      step(rand_data(), $urandom_range(0, 3) == 0, $urandom_range(0, NCHAN - 1), dv,
           $urandom_range(0, 15) == 0);
    end

    @(posedge clk_i);
    #2;
    check("scoreboard drained", DW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
